// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with parity/frame checking, 4x32 word FIFO and AHB-lite read port

`ifndef BUS_ADDR_UART_RECVDATA
`define BUS_ADDR_UART_RECVDATA 32'h4000_0010
`endif

module uart_rx #(
  parameter int BPS_115200      = 434,
  parameter int UART_DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel_rx,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        uartRx_int_clear,
  input  logic        RX,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic        irq_uartRx
);

  localparam int CW = (BPS_115200 > 2) ? $clog2(BPS_115200) : 1;
  localparam int BW = (UART_DATA_WIDTH > 2) ? $clog2(UART_DATA_WIDTH) : 1;
  localparam logic [CW-1:0] MID_CNT  = CW'(BPS_115200 / 2 - 1);
  localparam logic [CW-1:0] WRAP_CNT = CW'(BPS_115200 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_WIDTH - 1);
  localparam logic [31:0]   ADDR_DATA = `BUS_ADDR_UART_RECVDATA;
  localparam logic [31:0]   ADDR_STAT = ADDR_DATA + 32'd4;
  localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t state, next_state;

  logic                       rx_s1, rx_s2, rx_d;
  logic                       rx_fall;
  logic [CW-1:0]              bps_cnt;
  logic                       bit_mid, bit_end;
  logic [BW-1:0]              bit_cnt;
  logic [UART_DATA_WIDTH-1:0] shift_reg;
  logic                       par_bad;
  logic [1:0]                 byte_cnt;
  logic [31:0]                word_buf;
  logic [7:0]                 byte_val;
  logic [31:0]                word_full;
  logic                       stop_mid, byte_good;
  logic                       par_event, frame_event, ovf_event;
  logic                       push_req, push_ok, pop;

  logic [31:0]                fifo_mem [4];
  logic [1:0]                 wr_ptr, rd_ptr;
  logic [2:0]                 usedw;
  logic                       empty, full;

  logic                       parity_err, frame_err, overflow;
  logic                       nonseq, rd_data, rd_stat, wr_err;
  logic [31:0]                status_word;
  logic                       unused_bits;

  assign unused_bits = ^{HSIZE, HBURST, HWDATA};

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_fall = rx_d & ~rx_s2;
  assign bit_mid = (bps_cnt == MID_CNT);
  assign bit_end = (bps_cnt == WRAP_CNT);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next-state: bit periods end on bps_cnt wrap; STOP ends at its mid-bit sample
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (rx_fall) next_state = START;
      START: begin
        if (bit_mid && rx_s2) next_state = IDLE;
        else if (bit_end)     next_state = DATA;
      end
      DATA:    if (bit_end && (bit_cnt == LAST_BIT)) next_state = PARITY;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (bit_mid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bit-period counter, held at zero while idle so a start edge begins at count 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               bps_cnt <= '0;
    else if (state == IDLE)   bps_cnt <= '0;
    else if (bit_end)         bps_cnt <= '0;
    else                      bps_cnt <= bps_cnt + 1'b1;
  end

  assign stop_mid    = (state == STOP) && bit_mid;
  assign byte_good   = ~par_bad & rx_s2;
  assign par_event   = (state == PARITY) && bit_mid && ((^shift_reg) != rx_s2);
  assign frame_event = stop_mid && ~rx_s2;
  assign byte_val    = 8'(shift_reg);
  assign word_full   = {byte_val, word_buf[23:0]};
  assign push_req    = stop_mid && byte_good && (byte_cnt == 2'd3);

  // Data bit shifting, parity evaluation and little-endian word assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bad   <= 1'b0;
      byte_cnt  <= 2'd0;
      word_buf  <= 32'd0;
    end else begin
      if (state == IDLE) bit_cnt <= '0;
      if (state == DATA && bit_mid) shift_reg <= {rx_s2, shift_reg[UART_DATA_WIDTH-1:1]};
      if (state == DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
      if (state == PARITY && bit_mid) par_bad <= ((^shift_reg) != rx_s2);
      if (stop_mid) begin
        if (byte_good) begin
          word_buf[{byte_cnt, 3'b000} +: 8] <= byte_val;
          byte_cnt <= byte_cnt + 2'd1;
        end else begin
          byte_cnt <= 2'd0;
        end
      end
    end
  end

  assign empty     = (usedw == 3'd0);
  assign full      = (usedw == 3'd4);
  assign push_ok   = push_req & ~full;
  assign ovf_event = push_req & full;

  assign nonseq  = hsel_rx && (HTRANS == HTRANS_NONSEQ);
  assign rd_data = nonseq && !HWRITE && (HADDR == ADDR_DATA);
  assign rd_stat = nonseq && !HWRITE && (HADDR == ADDR_STAT);
  assign wr_err  = nonseq && HWRITE && ((HADDR == ADDR_DATA) || (HADDR == ADDR_STAT));
  assign pop     = rd_data & ~empty;

  // FIFO storage; contents need no reset since usedw guards every read
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= word_full;
  end

  // FIFO pointers and fill level; simultaneous push and pop leave usedw unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      usedw  <= 3'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   usedw <= usedw + 3'd1;
        2'b01:   usedw <= usedw - 3'd1;
        default: usedw <= usedw;
      endcase
    end
  end

  // Sticky error flags: cleared by a status read unless a new error lands the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (par_event)    parity_err <= 1'b1;
      else if (rd_stat) parity_err <= 1'b0;
      if (frame_event)  frame_err  <= 1'b1;
      else if (rd_stat) frame_err  <= 1'b0;
      if (ovf_event)    overflow   <= 1'b1;
      else if (rd_stat) overflow   <= 1'b0;
    end
  end

  // Receive interrupt: raised after a stored word, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                irq_uartRx <= 1'b0;
    else if (uartRx_int_clear) irq_uartRx <= 1'b0;
    else if (push_ok)          irq_uartRx <= 1'b1;
  end

  assign status_word = {25'd0, overflow, frame_err, parity_err, usedw, ~empty};

  // Registered bus response: data phase follows the NONSEQ address phase by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HRDATA <= 32'd0;
      HREADY <= 1'b1;
      HRESP  <= 2'b00;
    end else begin
      HREADY <= ~wr_err;
      HRESP  <= wr_err ? 2'b01 : 2'b00;
      if (rd_data)      HRDATA <= empty ? 32'd0 : fifo_mem[rd_ptr];
      else if (rd_stat) HRDATA <= status_word;
      else              HRDATA <= 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed table-driven bench for uart_rx

`ifndef BUS_ADDR_UART_RECVDATA
`define BUS_ADDR_UART_RECVDATA 32'h4000_0010
`endif

module tb_uart_rx;

  localparam int BPS = 16;
  localparam logic [31:0] A_DATA = `BUS_ADDR_UART_RECVDATA;
  localparam logic [31:0] A_STAT = A_DATA + 32'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel_rx;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        uartRx_int_clear;
  logic        RX;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic        irq_uartRx;

  int n_vec = 0;
  int n_bad = 0;

  uart_rx #(.BPS_115200(BPS), .UART_DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .hsel_rx(hsel_rx), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .uartRx_int_clear(uartRx_int_clear), .RX(RX), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .irq_uartRx(irq_uartRx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        bad_par;
    logic        bad_stop;
    logic [31:0] exp_status;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    RX = b;
    repeat (BPS) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ bad_par);
    send_bit(~bad_stop);
    send_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0, 1'b0);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    hsel_rx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(posedge clk);
    #1;
    data = HRDATA;
    hsel_rx = 1'b0; HTRANS = 2'b00; HADDR = 32'd0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    uartRx_int_clear = 1'b1;
    @(negedge clk);
    uartRx_int_clear = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] w;

    vecs[0]  = '{8'h78, 1'b0, 1'b0, 32'h00, 1'b0};
    vecs[1]  = '{8'h56, 1'b0, 1'b0, 32'h00, 1'b0};
    vecs[2]  = '{8'h34, 1'b0, 1'b0, 32'h00, 1'b0};
    vecs[3]  = '{8'h12, 1'b0, 1'b0, 32'h03, 1'b1};
    vecs[4]  = '{8'h11, 1'b0, 1'b0, 32'h03, 1'b0};
    vecs[5]  = '{8'h22, 1'b1, 1'b0, 32'h13, 1'b0};
    vecs[6]  = '{8'hAA, 1'b0, 1'b0, 32'h03, 1'b0};
    vecs[7]  = '{8'hBB, 1'b0, 1'b1, 32'h23, 1'b0};
    vecs[8]  = '{8'hAA, 1'b0, 1'b0, 32'h03, 1'b0};
    vecs[9]  = '{8'hBB, 1'b0, 1'b0, 32'h03, 1'b0};
    vecs[10] = '{8'hCC, 1'b0, 1'b0, 32'h03, 1'b0};
    vecs[11] = '{8'hDD, 1'b0, 1'b0, 32'h05, 1'b1};

    rst_n = 1'b0; RX = 1'b1; hsel_rx = 1'b0; HADDR = 32'd0; HWRITE = 1'b0;
    HSIZE = 3'd2; HBURST = 3'd0; HTRANS = 2'b00; HWDATA = 32'd0; uartRx_int_clear = 1'b0;
    repeat (4) @(negedge clk);
    check("reset irq", 32'(irq_uartRx), 32'd0);
    check("reset hrdata", HRDATA, 32'd0);
    check("reset hready", 32'(HREADY), 32'd1);
    check("reset hresp", 32'(HRESP), 32'd0);
    rst_n = 1'b1;
    repeat (2 * BPS) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      send_byte(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
      bus_read(A_STAT, rd);
      check($sformatf("vec%0d status", i), rd, vecs[i].exp_status);
      check($sformatf("vec%0d irq", i), 32'(irq_uartRx), 32'(vecs[i].exp_irq));
      pulse_clear();
    end

    bus_read(A_DATA, rd); check("word1 data", rd, 32'h12345678);
    bus_read(A_DATA, rd); check("word2 data", rd, 32'hDDCCBBAA);
    bus_read(A_DATA, rd); check("empty data", rd, 32'd0);
    bus_read(A_STAT, rd); check("drained status", rd, 32'd0);

    for (int i = 0; i < 5; i++) send_word(32'hA0B0C0D0 + 32'h01010101 * i);
    bus_read(A_STAT, rd); check("overflow status", rd, 32'h49);
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, rd);
      check($sformatf("ovf word%0d", i), rd, 32'hA0B0C0D0 + 32'h01010101 * i);
    end
    bus_read(A_STAT, rd); check("post ovf status", rd, 32'd0);
    pulse_clear();

    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (2 * BPS) @(negedge clk);
    bus_read(A_STAT, rd); check("glitch status", rd, 32'd0);
    check("glitch irq", 32'(irq_uartRx), 32'd0);

    send_byte(8'h9C, 1'b0, 1'b0);
    send_byte(8'h3E, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    uartRx_int_clear = 1'b1;
    send_byte(8'hF7, 1'b0, 1'b0);
    uartRx_int_clear = 1'b0;
    @(negedge clk);
    check("clear vs push irq", 32'(irq_uartRx), 32'd0);
    bus_read(A_STAT, rd); check("clear vs push status", rd, 32'h03);
    bus_read(A_DATA, rd); check("post glitch word", rd, 32'hF7013E9C);

    @(negedge clk);
    hsel_rx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_DATA;
    @(posedge clk); #1;
    check("write hready", 32'(HREADY), 32'd0);
    check("write hresp", 32'(HRESP), 32'd1);
    HTRANS = 2'b11; HADDR = A_STAT;
    @(posedge clk); #1;
    check("seq write hready", 32'(HREADY), 32'd1);
    check("seq write hresp", 32'(HRESP), 32'd0);
    hsel_rx = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0;

    send_word(32'hCAFEF00D);
    send_byte(8'h5A, 1'b1, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    check("pre reset irq", 32'(irq_uartRx), 32'd1);
    w = 32'h0000001F;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(w[i]);
    RX = w[4];
    repeat (BPS / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midframe reset irq", 32'(irq_uartRx), 32'd0);
    check("midframe reset hrdata", HRDATA, 32'd0);
    check("midframe reset hready", 32'(HREADY), 32'd1);
    check("midframe reset hresp", 32'(HRESP), 32'd0);
    repeat (3) @(negedge clk);
    RX = 1'b1;
    rst_n = 1'b1;
    repeat (2 * BPS) @(negedge clk);
    bus_read(A_STAT, rd); check("post reset status", rd, 32'd0);
    send_word(32'h04030201);
    check("post reset irq", 32'(irq_uartRx), 32'd1);
    bus_read(A_DATA, rd); check("post reset word", rd, 32'h04030201);
    bus_read(A_STAT, rd); check("final status", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
